// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported fixed-latency unified memory.
// One access at a time; registered done/rdata, combinational stalls.
module mem_arbiter #(
  parameter int LAT      = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_cancel,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_fetch,
  output logic        stall_mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [1:0]    state;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          cancel;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic          lat_wr;
  logic [15:0]   if_rdata_q;
  logic [15:0]   dm_rdata_q;
  logic          if_done_q;
  logic          dm_done_q;

  logic grant_if;
  logic grant_dm;
  logic wait_full;

  always_comb begin
    wait_full = (wcnt == WW'(MAX_WAIT));
    grant_if  = (state == S_IDLE) && if_req && (!dm_req || wait_full);
    grant_dm  = (state == S_IDLE) && dm_req && !grant_if;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      wcnt       <= '0;
      cancel     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_if) begin
            owner     <= OWN_IF;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            cnt       <= CW'(LAT - 1);
            cancel    <= 1'b0;
            wcnt      <= '0;
            state     <= S_BUSY;
          end else if (grant_dm) begin
            owner     <= OWN_DM;
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
            lat_wr    <= dm_wr;
            cnt       <= CW'(LAT - 1);
            cancel    <= 1'b0;
            // Only a fetch left waiting behind this grant counts toward starvation.
            if (!if_req)
              wcnt <= '0;
            else if (!wait_full)
              wcnt <= wcnt + WW'(1);
            state     <= S_BUSY;
          end else if (!if_req) begin
            wcnt <= '0;
          end
        end
        S_BUSY: begin
          if (owner == OWN_IF && if_cancel)
            cancel <= 1'b1;
          if (cnt == '0) begin
            state <= S_DONE;
            if (owner == OWN_DM) begin
              dm_rdata_q <= lat_wr ? '0 : mem_rdata;
              dm_done_q  <= 1'b1;
            end else if (!(cancel || if_cancel)) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == S_BUSY);
    mem_wr    = mem_en && lat_wr;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    // A flush landing in the completion cycle still kills the fetch result.
    if_done     = if_done_q && !if_cancel;
    dm_done     = dm_done_q;
    stall_fetch = rst_n && if_req && !if_done;
    stall_mem   = rst_n && dm_req && !dm_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-timeline model.
module tb_mem_arbiter;

  localparam int LAT  = 4;
  localparam int MAXW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, if_cancel, if_done, dm_req, dm_wr, dm_done;
  logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr, stall_fetch, stall_mem;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_if_req, b_if_cancel, b_if_done, b_dm_req, b_dm_wr, b_dm_done;
  logic [15:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic        b_mem_en, b_mem_wr, b_stall_fetch, b_stall_mem;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.LAT(LAT), .MAX_WAIT(MAXW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  mem_arbiter #(.LAT(1), .MAX_WAIT(MAXW)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_cancel(b_if_cancel),
    .if_rdata(b_if_rdata), .if_done(b_if_done),
    .dm_req(b_dm_req), .dm_wr(b_dm_wr), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_done(b_dm_done),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_fetch(b_stall_fetch), .stall_mem(b_stall_mem)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each transaction is a grant cycle t; memory busy t+1..t+LAT, done at t+LAT+1.
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_own = 0;      // 0 fetch, 1 data
  int          m_t = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  bit          m_wr = 0;
  bit          m_cancel = 0;
  int          m_wcnt = 0;
  logic [15:0] m_if_rd = '0;
  logic [15:0] m_dm_rd = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_active = 0; m_wcnt = 0; m_cancel = 0; m_if_rd = '0; m_dm_rd = '0;
      end else if (m_active) begin
        if (!m_own && if_cancel && cyc <= m_t + LAT) m_cancel = 1;
        if (cyc == m_t + LAT) begin
          if (m_own) m_dm_rd = m_wr ? 16'h0 : mem_rdata;
          else if (!m_cancel) m_if_rd = mem_rdata;
        end
        if (cyc == m_t + LAT + 1) m_active = 0;
      end else if (if_req || dm_req) begin
        m_active = 1; m_t = cyc; m_cancel = 0;
        m_own = dm_req && !(if_req && m_wcnt == MAXW);
        m_addr = m_own ? dm_addr : if_addr;
        m_wr = m_own && dm_wr;
        m_wdata = dm_wdata;
        if (!if_req || !m_own) m_wcnt = 0;
        else if (m_wcnt < MAXW) m_wcnt = m_wcnt + 1;
      end else begin
        m_wcnt = 0;
      end
      cyc++;
    end
  end

  bit e_busy, e_donec, e_if_done, e_dm_done;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_stall_fetch", stall_fetch, 0);
        chk("rst_stall_mem", stall_mem, 0);
      end else begin
        e_busy    = m_active && cyc <= m_t + LAT;
        e_donec   = m_active && cyc == m_t + LAT + 1;
        e_if_done = e_donec && !m_own && !m_cancel && !if_cancel;
        e_dm_done = e_donec && m_own;
        chk("mem_en", mem_en, e_busy);
        chk("mem_wr", mem_wr, e_busy && m_wr);
        if (e_busy) chk("mem_addr", mem_addr, m_addr);
        if (e_busy && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_done", if_done, e_if_done);
        chk("dm_done", dm_done, e_dm_done);
        if (e_if_done) chk("if_rdata", if_rdata, m_if_rd);
        chk("dm_rdata", dm_rdata, m_dm_rd);
        chk("stall_fetch", stall_fetch, if_req && !e_if_done);
        chk("stall_mem", stall_mem, dm_req && !e_dm_done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int en_cnt, done_at, done2_at, dm_before, en_mask, done_mask, rst_hold;
  bit got_if, saw;

  initial begin
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; if_cancel = 0; dm_req = 0; dm_wr = 0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    b_if_req = 0; b_if_addr = '0; b_if_cancel = 0; b_dm_req = 0; b_dm_wr = 0;
    b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single load
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0040; mem_rdata = 16'hBEEF;
    #1 chk("d1_stall_c0", stall_mem, 1);
    en_cnt = 0; done_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_en) begin en_cnt++; chk("d1_addr", mem_addr, 16'h0040); end
      if (dm_done) begin
        done_at = i;
        chk("d1_rdata", dm_rdata, 16'hBEEF);
        chk("d1_stall_done", stall_mem, 0);
        dm_req = 0;
      end else if (i < 5) chk("d1_stall_busy", stall_mem, 1);
    end
    chk("d1_en_cycles", en_cnt, 4);
    chk("d1_done_at", done_at, 5);

    // Simultaneous fetch and store
    repeat (2) tick();
    if_req = 1; if_addr = 16'h0100;
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234; mem_rdata = 16'hCAFE;
    done_at = -1; done2_at = -1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) begin
        chk("d2_mem_wr", mem_wr, 1);
        chk("d2_mem_wdata", mem_wdata, 16'h1234);
        chk("d2_mem_addr_dm", mem_addr, 16'h0200);
      end
      if (i == 7) begin
        chk("d2_mem_addr_if", mem_addr, 16'h0100);
        chk("d2_mem_wr_if", mem_wr, 0);
      end
      if (dm_done) begin done_at = i; chk("d2_dm_rdata", dm_rdata, 16'h0000); dm_req = 0; end
      if (if_done) begin done2_at = i; chk("d2_if_rdata", if_rdata, 16'hCAFE); if_req = 0; end
    end
    dm_wr = 0;
    chk("d2_dm_done_at", done_at, 5);
    chk("d2_if_done_at", done2_at, 11);

    // Starvation bound, twice to show the wait count restarts
    for (int rep = 0; rep < 2; rep++) begin
      repeat (2) tick();
      if_req = 1; if_addr = 16'h0300; dm_req = 1; dm_wr = 0; dm_addr = 16'h0400;
      dm_before = 0; got_if = 0;
      for (int i = 0; i < 60 && !got_if; i++) begin
        tick();
        mem_rdata = 16'($urandom);
        if (dm_done) begin dm_before++; dm_req = 0; end
        else dm_req = 1;
        if (if_done) begin got_if = 1; if_req = 0; end
      end
      chk("d3_dm_grants", dm_before, 3);
      chk("d3_if_done", got_if, 1);
      saw = 0;
      for (int i = 0; i < 20 && !saw; i++) begin
        tick();
        if (dm_done) begin saw = 1; dm_req = 0; end
      end
      chk("d3_drain", saw, 1);
    end

    // Flush during the second busy cycle
    repeat (2) tick();
    if_req = 1; if_addr = 16'h0004;
    en_cnt = 0; saw = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_en) en_cnt++;
      if (if_done) saw = 1;
      if (i == 2) begin if_cancel = 1; if_req = 0; end
      else if_cancel = 0;
    end
    chk("d4_en_cycles", en_cnt, 4);
    chk("d4_no_done", saw, 0);
    if_req = 1; if_addr = 16'h0008; mem_rdata = 16'h5A5A; done_at = -1;
    for (int i = 1; i <= 20 && done_at < 0; i++) begin
      tick();
      if (if_done) begin done_at = i; chk("d4_rdata", if_rdata, 16'h5A5A); if_req = 0; end
    end
    chk("d4_fetch_lat", done_at, 5);

    // Reset in the third busy cycle
    repeat (2) tick();
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0044; mem_rdata = 16'h1111;
    repeat (3) tick();
    rst_n = 0;
    #1;
    chk("d5_mem_en", mem_en, 0);
    chk("d5_dm_done", dm_done, 0);
    chk("d5_dm_rdata", dm_rdata, 0);
    chk("d5_if_rdata", if_rdata, 0);
    chk("d5_stall_mem", stall_mem, 0);
    repeat (2) tick();
    rst_n = 1; mem_rdata = 16'h2222;
    en_cnt = 0; done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_en) en_cnt++;
      if (dm_done) begin done_at = i; chk("d5_rdata", dm_rdata, 16'h2222); dm_req = 0; end
    end
    chk("d5_en_cycles", en_cnt, 4);
    chk("d5_done_at", done_at, 5);

    // LAT=1 instance: back-to-back loads
    b_dm_req = 1; b_dm_addr = 16'h0050; b_mem_rdata = 16'h7777;
    en_mask = 0; done_mask = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (b_mem_en) en_mask |= (1 << i);
      if (b_dm_done) begin
        done_mask |= (1 << i);
        chk("d6_rdata", b_dm_rdata, 16'h7777);
        b_dm_req = 0;
      end
      if (i == 3) b_dm_req = 1;
    end
    chk("d6_en_mask", en_mask, 32'h12);
    chk("d6_done_mask", done_mask, 32'h24);

    // Random traffic with flushes and occasional resets
    rst_hold = 0;
    for (int n = 0; n < 2000; n++) begin
      tick();
      mem_rdata = 16'($urandom);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1;
        continue;
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0; rst_hold = 2; if_req = 0; dm_req = 0; if_cancel = 0;
        continue;
      end
      if_cancel = ($urandom_range(0, 19) == 0);
      if (if_req) begin
        if (if_cancel || if_done) if_req = 0;
      end else if (!if_cancel && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (dm_req) begin
        if (dm_done) dm_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_wr = 1'($urandom); dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      end
    end
    rst_n = 1; if_req = 0; dm_req = 0; if_cancel = 0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
